// File: rtl/ex_iter.sv
// rtl/ex_iter.sv - execute stage with single-cycle ALU and iterative unsigned divider
//
// Purpose: logic/shift/arith ops are registered with a latency of 1 cycle.
//          DIVU/REMU with a non-zero divisor run a restoring divider for DW
//          cycles. While it runs, ready_o is low and stallreq_o is high.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   valid_i / ready_o         op handshake (accept = valid_i & ready_o)
//   flush_i                   kill the in-flight op and the output register
//   aluop_i, alusel_i         operation code and result group
//   reg1_i, reg2_i            operands (reg1_i[SHW-1:0] is the shift amount)
//   wd_i, wreg_i              destination address and write enable
//   valid_o, wd_o, wreg_o,
//   wdata_o                   registered result (EX/MEM register)
//   stallreq_o                stall request while the divider is busy
// Optional feature: define EX_ITER_MUL_EN to add MUL (alusel 3'b101, aluop 0xA9).
module ex_iter #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int SHW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          flush_i,
    input  logic [7:0]    aluop_i,
    input  logic [2:0]    alusel_i,
    input  logic [DW-1:0] reg1_i,
    input  logic [DW-1:0] reg2_i,
    input  logic [AW-1:0] wd_i,
    input  logic          wreg_i,
    output logic          valid_o,
    output logic [AW-1:0] wd_o,
    output logic          wreg_o,
    output logic [DW-1:0] wdata_o,
    output logic          stallreq_o
);
    localparam int CW = SHW + 1;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_DIV   = 3'b101;

    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_REMU = 8'h1C;
`ifdef EX_ITER_MUL_EN
    localparam logic [7:0] OP_MUL  = 8'hA9;
`endif

    typedef enum logic {IDLE, DIV_RUN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] alu_res;
    logic          div_start;
    logic          accept;

    logic [DW-1:0] quo_q, rem_q, dvs_q;
    logic [DW-1:0] quo_n, rem_n;
    logic [DW:0]   trial;
    logic [CW-1:0] cnt_q;
    logic          is_rem_q;
    logic [AW-1:0] div_wd_q;
    logic          div_wreg_q;

    assign accept = valid_i & ready_o;

    // Single-cycle result; a zero divisor is resolved here so it never stalls.
    always_comb begin
        alu_res   = '0;
        div_start = 1'b0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_AND:  alu_res = reg1_i & reg2_i;
                    OP_OR:   alu_res = reg1_i | reg2_i;
                    OP_XOR:  alu_res = reg1_i ^ reg2_i;
                    OP_NOR:  alu_res = ~(reg1_i | reg2_i);
                    default: alu_res = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  alu_res = reg2_i << reg1_i[SHW-1:0];
                    OP_SRL:  alu_res = reg2_i >> reg1_i[SHW-1:0];
                    OP_SRA:  alu_res = $unsigned($signed(reg2_i) >>> reg1_i[SHW-1:0]);
                    default: alu_res = '0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADDU: alu_res = reg1_i + reg2_i;
                    OP_SUBU: alu_res = reg1_i - reg2_i;
                    OP_SLT:  alu_res = {{(DW-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
                    OP_SLTU: alu_res = {{(DW-1){1'b0}}, reg1_i < reg2_i};
                    default: alu_res = '0;
                endcase
            end
            SEL_DIV: begin
                case (aluop_i)
                    OP_DIVU: begin
                        if (reg2_i == '0) alu_res = '1;
                        else              div_start = 1'b1;
                    end
                    OP_REMU: begin
                        if (reg2_i == '0) alu_res = reg1_i;
                        else              div_start = 1'b1;
                    end
`ifdef EX_ITER_MUL_EN
                    OP_MUL:  alu_res = reg1_i * reg2_i;
`endif
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor. The borrow bit decides whether the
    // subtraction is kept.
    always_comb begin
        trial = {rem_q, quo_q[DW-1]} - {1'b0, dvs_q};
        rem_n = trial[DW] ? {rem_q[DW-2:0], quo_q[DW-1]} : trial[DW-1:0];
        quo_n = {quo_q[DW-2:0], ~trial[DW]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && div_start) state_nxt = DIV_RUN;
                DIV_RUN: if (cnt_q == CW'(1))     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o    = (state == IDLE);
        stallreq_o = (state == DIV_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o    <= 1'b0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            is_rem_q   <= 1'b0;
            div_wd_q   <= '0;
            div_wreg_q <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && div_start) begin
                        quo_q      <= reg1_i;
                        rem_q      <= '0;
                        dvs_q      <= reg2_i;
                        cnt_q      <= CW'(DW);
                        is_rem_q   <= (aluop_i == OP_REMU);
                        div_wd_q   <= wd_i;
                        div_wreg_q <= wreg_i;
                        valid_o    <= 1'b0;
                        wreg_o     <= 1'b0;
                    end else if (accept) begin
                        valid_o <= 1'b1;
                        wd_o    <= wd_i;
                        wreg_o  <= wreg_i;
                        wdata_o <= alu_res;
                    end else begin
                        valid_o <= 1'b0;
                        wreg_o  <= 1'b0;
                    end
                end
                DIV_RUN: begin
                    quo_q <= quo_n;
                    rem_q <= rem_n;
                    cnt_q <= cnt_q - CW'(1);
                    // The last step's result goes straight to the output register.
                    if (cnt_q == CW'(1)) begin
                        valid_o <= 1'b1;
                        wd_o    <= div_wd_q;
                        wreg_o  <= div_wreg_q;
                        wdata_o <= is_rem_q ? rem_n : quo_n;
                    end else begin
                        valid_o <= 1'b0;
                        wreg_o  <= 1'b0;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    wreg_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_iter.sv
// tb/tb_ex_iter.sv - randomized self-checking bench for ex_iter
module tb_ex_iter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic          flush_i;
    logic [7:0]    aluop_i;
    logic [2:0]    alusel_i;
    logic [DW-1:0] reg1_i;
    logic [DW-1:0] reg2_i;
    logic [AW-1:0] wd_i;
    logic          wreg_i;
    logic          valid_o;
    logic [AW-1:0] wd_o;
    logic          wreg_o;
    logic [DW-1:0] wdata_o;
    logic          stallreq_o;

    int checks = 0;
    int errors = 0;

    ex_iter #(.DW(DW), .AW(AW), .SHW(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .flush_i(flush_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_long_div(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] b);
        return (sel == 3'b101) && (op == 8'h1B || op == 8'h1C) && (b != 0);
    endfunction

    // Reference result computed with wide integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] sel, input logic [7:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          sb = longint'($signed(b));
        int unsigned     sh = a % 32;
        case ({sel, op})
            {3'b001, 8'h24}: return a & b;
            {3'b001, 8'h25}: return a | b;
            {3'b001, 8'h26}: return a ^ b;
            {3'b001, 8'h27}: return ~(a | b);
            {3'b010, 8'h7C}: return 32'((ub * (64'd1 << sh)) % (64'd1 << 32));
            {3'b010, 8'h02}: return 32'(ub / (64'd1 << sh));
            {3'b010, 8'h03}: return 32'(sb >>> sh);
            {3'b100, 8'h21}: return 32'((ua + ub) % (64'd1 << 32));
            {3'b100, 8'h23}: return 32'((ua + (64'd1 << 32) - ub) % (64'd1 << 32));
            {3'b100, 8'h2A}: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            {3'b100, 8'h2B}: return (ua < ub) ? 32'd1 : 32'd0;
            {3'b101, 8'h1B}: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            {3'b101, 8'h1C}: return (b == 0) ? a : a % b;
`ifdef EX_ITER_MUL_EN
            {3'b101, 8'hA9}: return 32'((ua * ub) % (64'd1 << 32));
`endif
            default:         return 32'd0;
        endcase
    endfunction

    // Issue one op at a negedge, wait (bounded) for the result and check it.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd, input logic wr);
        int n = 0;
        int stall_n = 0;
        int exp_st;
        logic [31:0] exp_d;
        exp_d  = model(sel, op, a, b);
        exp_st = is_long_div(sel, op, b) ? DW : 0;
        check({tag, "_ready"}, ready_o, 1);
        alusel_i = sel; aluop_i = op; reg1_i = a; reg2_i = b;
        wd_i = wd; wreg_i = wr; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        reg1_i = $urandom; reg2_i = $urandom; wd_i = 5'($urandom); wreg_i = 1'($urandom);
        while (valid_o !== 1'b1 && n < DW + 10) begin
            if (stallreq_o === 1'b1 && ready_o === 1'b0) stall_n++;
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, n, exp_st);
        check({tag, "_stall"}, stall_n, exp_st);
        check({tag, "_valid"}, valid_o, 1);
        check({tag, "_wdata"}, wdata_o, exp_d);
        check({tag, "_wd"}, wd_o, wd);
        check({tag, "_wreg"}, wreg_o, wr);
        check({tag, "_nostall"}, stallreq_o, 0);
        @(negedge clk);
        check({tag, "_valid_drop"}, valid_o, 0);
        check({tag, "_wreg_drop"}, wreg_o, 0);
        check({tag, "_hold"}, wdata_o, exp_d);
    endtask

    task automatic watch_no_result(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid_o === 1'b1) seen++;
        end
        check(tag, seen, 0);
    endtask

    logic [10:0] pairs [0:19] = '{
        {3'b001, 8'h24}, {3'b001, 8'h25}, {3'b001, 8'h26}, {3'b001, 8'h27},
        {3'b010, 8'h7C}, {3'b010, 8'h02}, {3'b010, 8'h03},
        {3'b100, 8'h21}, {3'b100, 8'h23}, {3'b100, 8'h2A}, {3'b100, 8'h2B},
        {3'b101, 8'h1B}, {3'b101, 8'h1C}, {3'b101, 8'h1B}, {3'b101, 8'h1C},
        {3'b101, 8'hA9}, {3'b001, 8'h21}, {3'b000, 8'h24}, {3'b111, 8'h1B},
        {3'b010, 8'h25}
    };

    initial begin
        logic [10:0] p;
        logic [31:0] b;
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; aluop_i = '0; alusel_i = '0;
        reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_wreg", wreg_o, 0);
        check("rst_wd", wd_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_stall", stallreq_o, 0);
        check("rst_ready", ready_o, 1);
        rst = 1'b0;
        @(negedge clk);

        run_op("or",    3'b001, 8'h25, 32'h0F0F_0000, 32'h0000_F0F0, 5'd3, 1'b1);
        run_op("sra",   3'b010, 8'h03, 32'd4, 32'h8000_0010, 5'd4, 1'b1);
        run_op("slt",   3'b100, 8'h2A, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
        run_op("sltu",  3'b100, 8'h2B, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b0);
        run_op("divu",  3'b101, 8'h1B, 32'd100, 32'd7, 5'd7, 1'b1);
        run_op("remu",  3'b101, 8'h1C, 32'd100, 32'd7, 5'd8, 1'b1);
        run_op("divu0", 3'b101, 8'h1B, 32'd5, 32'd0, 5'd9, 1'b1);
        run_op("remu0", 3'b101, 8'h1C, 32'd5, 32'd0, 5'd10, 1'b1);
        run_op("mul",   3'b101, 8'hA9, 32'h0001_0000, 32'h0001_0003, 5'd11, 1'b1);
        run_op("badop", 3'b001, 8'h21, 32'h1234, 32'h5678, 5'd12, 1'b1);

        // Flush on the 10th busy cycle of a division.
        alusel_i = 3'b101; aluop_i = 8'h1B; reg1_i = 32'd100; reg2_i = 32'd7;
        wd_i = 5'd13; wreg_i = 1'b1; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy", stallreq_o, 1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_valid", valid_o, 0);
        check("flush_stall", stallreq_o, 0);
        check("flush_ready", ready_o, 1);
        watch_no_result("flush_noresult", 40);

        // Input presented together with flush is dropped.
        alusel_i = 3'b001; aluop_i = 8'h25; reg1_i = 32'h1; reg2_i = 32'h2;
        valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        check("flushin_valid", valid_o, 0);
        check("flushin_wreg", wreg_o, 0);

        run_op("after_flush", 3'b100, 8'h21, 32'hFFFF_FFFF, 32'd2, 5'd14, 1'b1);

        // Asynchronous reset in the middle of a division.
        alusel_i = 3'b101; aluop_i = 8'h1C; reg1_i = 32'd100; reg2_i = 32'd7;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_stall", stallreq_o, 0);
        check("arst_valid", valid_o, 0);
        check("arst_wdata", wdata_o, 0);
        check("arst_wd", wd_o, 0);
        check("arst_ready", ready_o, 1);
        @(negedge clk);
        rst = 1'b0;
        watch_no_result("arst_noresult", 40);

        for (int i = 0; i < 60; i++) begin
            p = pairs[$urandom_range(0, 19)];
            case ($urandom_range(0, 2))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 300);
                default: b = $urandom;
            endcase
            run_op("rnd", p[10:8], p[7:0], $urandom, b, 5'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_iter.md
Name: ex_iter

Overview:
- Parametrised next-generation execute stage for the in-order pipeline; sits between the ID/EX and EX/MEM stages.
- Implements single-cycle logic, shift and arithmetic ops, plus an iterative unsigned divider.
- Output is registered, so the EX/MEM register is folded into this block.
- A valid/ready handshake and a stall request let the multi-cycle divider hold the upstream pipeline.

Parameters:
- DW, 32, datapath width in bits; must be at least 8 and a power of two.
- AW, 5, register-address width (width of wd_i / wd_o).
- SHW, 5, shift-amount width; must equal log2(DW). Only reg1_i[SHW-1:0] is used as the shift amount.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  an operation is present on the inputs.
- ready_o  out  1  block accepts an op this cycle.
- flush_i  in  1  kill the in-flight op and the output register.
- aluop_i  in  8  operation code.
- alusel_i  in  3  result group.
- reg1_i  in  DW  operand A; also supplies the shift amount.
- reg2_i  in  DW  operand B; also the value being shifted.
- wd_i  in  AW  destination register address.
- wreg_i  in  1  write-enable request.
- valid_o  out  1  output register holds a result.
- wd_o  out  AW  registered destination address.
- wreg_o  out  1  registered write enable.
- wdata_o  out  DW  registered result.
- stallreq_o  out  1  stall request to the pipeline controller.

Behaviour:
- Reset (asynchronous, rst=1):
  - valid_o=0, wreg_o=0, wd_o=0, wdata_o=0, stallreq_o=0.
  - FSM goes to IDLE; divider registers are cleared.
- alusel_i encodings: LOGIC 3'b001, SHIFT 3'b010, ARITH 3'b100, DIV 3'b101.
- aluop_i encodings:
  - LOGIC group: AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - SHIFT group: SLL 0x7C, SRL 0x02, SRA 0x03.
  - ARITH group: ADDU 0x21, SUBU 0x23, SLT 0x2A (signed), SLTU 0x2B.
  - DIV group: DIVU 0x1B (quotient), REMU 0x1C (remainder).
- Result rules:
  - Arithmetic wraps modulo 2^DW; there is no overflow trap.
  - SLT and SLTU return 1 or 0, zero-extended to DW.
  - If aluop_i does not belong to the alusel_i group, or either code is unknown: wdata_o=0, wreg_o still follows wreg_i.
- Accept condition: an op is accepted when valid_i & ready_o.
- FSM states: IDLE, DIV_RUN.
- IDLE:
  - ready_o=1.
  - Accepted non-DIV op: on the next edge valid_o=1 and wd_o/wreg_o/wdata_o are loaded. Latency is 1 cycle.
  - No accept: on the next edge valid_o=0 and wreg_o=0; wd_o and wdata_o hold their values.
  - Accepted DIV op with reg2_i==0: completes in 1 cycle. DIVU gives all ones; REMU gives reg1_i.
  - Accepted DIV op with reg2_i!=0: operands, wd and wreg are latched; a counter is set to DW; state goes to DIV_RUN; valid_o=0.
- DIV_RUN:
  - ready_o=0 and stallreq_o=1.
  - Each cycle performs one restoring shift-subtract step and decrements the counter.
  - When the counter reaches 0: the output register is loaded (quotient or remainder), valid_o=1, and state returns to IDLE.
  - Total latency from accept to valid_o is DW+1 cycles.
  - stallreq_o is combinational and is 1 for exactly DW cycles.
- flush_i:
  - Has priority over everything else.
  - On the next edge: valid_o=0, wreg_o=0, FSM to IDLE, stallreq_o=0. Any input presented in the same cycle is dropped.
- Simultaneous completion and new input: in the cycle the divider finishes, ready_o=0; the next op is accepted the following cycle.
- Reset mid-division: the divider is aborted immediately and no result is emitted.

Optional Feature:
- Macro: EX_ITER_MUL_EN.
- Defined:
  - Adds MUL (aluop 0xA9, alusel DIV group 3'b101).
  - Returns the low DW bits of the unsigned product reg1_i*reg2_i.
  - Single-cycle, registered, latency 1; no stall.
- Undefined:
  - 0xA9 is treated as an unknown op: wdata_o=0, latency 1.
  - No multiplier logic is synthesised.

Test Plan:
- Reset, then release; drive OR (0x25/001), A=0x0F0F0000, B=0x0000F0F0, wd=3, wreg=1 -> next cycle valid_o=1, wdata_o=0x0F0FF0F0, wd_o=3, wreg_o=1.
- SRA (0x03/010), A=4, B=0x80000010 -> wdata_o=0xF8000001. SLT with A=0xFFFFFFFF, B=1 -> wdata_o=1; SLTU with the same operands -> wdata_o=0.
- DIVU, A=100, B=7:
  - stallreq_o=1 and ready_o=0 for exactly 32 cycles.
  - Then valid_o=1, wdata_o=14. REMU with the same operands -> wdata_o=2.
- DIVU, A=5, B=0 -> 1-cycle result 0xFFFFFFFF with no stall. REMU, A=5, B=0 -> wdata_o=5.
- Start DIVU, A=100, B=7:
  - Assert flush_i on the 10th busy cycle -> next edge valid_o=0, stallreq_o=0, ready_o=1; no result is ever emitted.
  - Repeat with rst pulsed mid-division -> all outputs go to 0 asynchronously.
- With EX_ITER_MUL_EN defined: MUL, A=0x10000, B=0x10003 -> wdata_o=0x00030000 (low word). Without the macro -> wdata_o=0.
